nibble_seq_adder: RTL
=====================

// Module: nibble_seq_adder
// PURPOSE
//  Multi-cycle sequencer that adds two WIDTH-bit operands with one shared 4-bit ripple adder cell.
//  It processes one nibble per clock, LSB first, and holds the inter-nibble carry in a register.
//  Sits between a requesting datapath (start/done handshake) and the 4-bit adder resource,
//  trading latency for area in wide additions.
// PARAMETERS
//  WIDTH    16   operand/result width in bits; must be a multiple of 4 and >= 8
//  NIBBLES  WIDTH/4   derived localparam; number of RUN cycles per operation
// PORTS
//  clk      in   1      single clock; all state updates on rising edge
//  reset_n  in   1      asynchronous, active-low reset; deassertion is synchronised externally
//  start    in   1      request; sampled only in IDLE or DONE
//  a        in   WIDTH  operand A; captured on an accepted start
//  b        in   WIDTH  operand B; captured on an accepted start
//  cin      in   1      carry-in to nibble 0; captured on an accepted start
//  busy     out  1      high while state == RUN
//  done     out  1      one-cycle pulse; sum/cout valid
//  sum      out  WIDTH  registered result; held until the next completion
//  cout     out  1      registered carry-out of the top nibble; held like sum
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, nib_idx=0, carry=0, busy=0, done=0, sum=0, cout=0.
//  FSM states IDLE -> RUN -> DONE:
//   IDLE: start=1 -> capture a, b, cin, and sub (if enabled); nib_idx=0; go to RUN.
//   RUN: adder inputs are a_q[4k+3:4k], b_q[4k+3:4k] and carry. Each cycle: acc[4k+3:4k] <= nibble sum;
//        carry <= nibble cout; nib_idx++. When nib_idx == NIBBLES-1: sum <= final acc, cout <= final carry; go to DONE.
//   DONE: done=1 for exactly this cycle. start=1 -> capture and go to RUN (back-to-back); else go to IDLE.
//  Latency: start accepted on edge t -> done high during cycle t+NIBBLES+1; throughput 1 op per NIBBLES+1 cycles.
//  start while RUN is ignored: no capture, no error, operands are unaffected.
//  Operand inputs may change after acceptance; only captured copies are used.
//  sum/cout change only on the RUN->DONE edge, never mid-operation. nib_idx wraps to 0 on each accept.
//  Arithmetic: modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1. No overflow flag.
//  Reset mid-RUN: operation is abandoned, every output returns to reset value, and no done is issued.
// CONFIGURATION
//  Macro NIBBLE_SEQ_SUB_EN:
//   Defined: adds input port `sub` (1 bit, captured with the operands).
//     sub=1 computes a - b as a + ~b + 1: B nibbles inverted, nibble-0 carry forced to 1, cin ignored.
//     cout=1 means no borrow.
//   Undefined: no `sub` port; the block is add-only. Port list and timing are otherwise identical.
// STRUCTURE
//  Shared package nibble_seq_pkg:
//   - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//   - NIB_W=4
//   - index-width helper function clog2 for nib_idx
//  One sub-module, nibble_add4:
//   - purely combinational 4-bit ripple adder with ports (a[3:0], b[3:0], ci, s[3:0], co)
//   - instantiated exactly once
//   - all sequencing, muxing, and carry registration stay in the parent
// TESTING (WIDTH=16, NIBBLES=4)
//  1. a=16'h1234, b=16'h4321, cin=0, start pulse -> busy for 4 cycles; done on 5th cycle; sum=16'h5555, cout=0.
//  2. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Check carry ripples across all 4 nibbles.
//  3. Repeat case 1 and pulse start with a=16'hAAAA during RUN -> ignored; result is still 16'h5555.
//     sum stays at its prior value until done.
//  4. Assert reset_n=0 on the 2nd RUN cycle -> outputs immediately 0/IDLE.
//     After release: no done; a new start with 16'h0F0F+16'h00F1 gives 16'h1000.
//  5. Hold start high through DONE with new operands 16'h0001+16'h0001.
//     Expect back-to-back RUN with no IDLE cycle; second done 5 cycles after the first, sum=16'h0002.
//  6. With NIBBLE_SEQ_SUB_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0.
//     a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.

Source files
------------

// File: rtl/nibble_seq_pkg.sv
// ---------------------------------------------------------------------------------------------
// nibble_seq_pkg
// Shared definitions for the nibble-serial adder: FSM state encoding, nibble width and an
// index-width helper used to size the nibble counter.
// ---------------------------------------------------------------------------------------------
package nibble_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// ---------------------------------------------------------------------------------------------
// nibble_add4
// Purely combinational 4-bit ripple-carry adder cell shared by the nibble sequencer.
// Ports:
//   i_a, i_b  in  4   addend nibbles
//   i_ci      in  1   carry in
//   o_s       out 4   sum nibble
//   o_co      out 1   carry out of bit 3
// ---------------------------------------------------------------------------------------------
module nibble_add4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);

  logic w_c;

  always_comb begin
    w_c = i_ci;
    o_s = '0;
    for (int i = 0; i < 4; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/nibble_seq_adder.sv
// ---------------------------------------------------------------------------------------------
// nibble_seq_adder
// Adds two WIDTH-bit operands one nibble per clock (LSB first) through a single shared 4-bit
// ripple adder, keeping the inter-nibble carry in a register. Start/done handshake.
// Optional feature macro: NIBBLE_SEQ_SUB_EN adds i_sub (a - b computed as a + ~b + 1).
// Ports:
//   i_clk      in  1      clock, rising edge
//   i_reset_n  in  1      asynchronous active-low reset
//   i_start    in  1      request, sampled only in IDLE or DONE
//   i_a, i_b   in  WIDTH  operands, captured on accepted start
//   i_cin      in  1      carry into nibble 0, captured on accepted start
//   i_sub      in  1      (NIBBLE_SEQ_SUB_EN only) subtract, captured with operands
//   o_busy     out 1      high while running
//   o_done     out 1      one-cycle completion pulse
//   o_sum      out WIDTH  registered result, held until next completion
//   o_cout     out 1      registered carry out of the top nibble
// ---------------------------------------------------------------------------------------------
module nibble_seq_adder
  import nibble_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef NIBBLE_SEQ_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned NIBBLES = WIDTH / NIB_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [IDX_W-1:0] r_nib_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef NIBBLE_SEQ_SUB_EN
  logic             r_sub;
`endif

  logic             w_accept;
  logic             w_last;
  logic [IDX_W+1:0] w_bit_base;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s;
  logic             w_co;

  assign w_accept   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_nib_idx == LAST_IDX);
  // Nibble k starts at bit 4k; the two appended zeros multiply the index by NIB_W.
  assign w_bit_base = {r_nib_idx, 2'b00};
  assign w_a_nib    = r_a[w_bit_base +: NIB_W];
`ifdef NIBBLE_SEQ_SUB_EN
  assign w_b_nib    = r_b[w_bit_base +: NIB_W] ^ {NIB_W{r_sub}};
`else
  assign w_b_nib    = r_b[w_bit_base +: NIB_W];
`endif

  nibble_add4 u_add4 (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)  w_state_next = ST_DONE;
      ST_DONE: w_state_next = i_start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_RUN:  o_busy = 1'b1;
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, nibble datapath and result registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_nib_idx <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
`ifdef NIBBLE_SEQ_SUB_EN
      r_sub     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a       <= i_a;
      r_b       <= i_b;
      r_nib_idx <= '0;
`ifdef NIBBLE_SEQ_SUB_EN
      r_sub     <= i_sub;
      // Two's-complement subtract supplies the +1 through the nibble-0 carry.
      r_carry   <= i_sub ? 1'b1 : i_cin;
`else
      r_carry   <= i_cin;
`endif
    end else if (r_state == ST_RUN) begin
      r_acc[w_bit_base +: NIB_W] <= w_s;
      r_carry                    <= w_co;
      if (w_last) begin
        r_nib_idx <= '0;
        // The top nibble is produced this cycle, so it bypasses r_acc.
        r_sum     <= {w_s, r_acc[WIDTH-NIB_W-1:0]};
        r_cout    <= w_co;
      end else begin
        r_nib_idx <= r_nib_idx + IDX_W'(1);
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule
